// File: rtl/timerwithclock_button_conditioner.sv
// Four-channel push-button conditioner: synchronise, debounce, edge pulses
// and hold-to-repeat ticks for the alarm-clock time-setting logic.
//
// Repeat FSM (per channel):
//   state      | meaning
//   RPT_IDLE   | button released or repeat disabled on this channel
//   RPT_DELAY  | pressed, waiting out the initial hold delay
//   RPT_REPEAT | held past the delay, ticking every repeat period
module timerwithclock_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES      = 1000000,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 5000000,
  parameter logic [3:0]  REPEAT_MASK          = 4'b1111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_tick
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                 REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DCNT_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RDLY_TC = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] RPER_TC = RW'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [DW-1:0] dcnt_q [4];
  logic [DW-1:0] dcnt_d [4];
  logic [3:0]    level_q, level_d;
  logic [3:0]    press_q, press_d;
  logic [3:0]    release_q, release_d;
  logic [3:0]    tick_q, tick_d;
  rpt_state_e    state_q [4];
  rpt_state_e    state_d [4];
  logic [RW-1:0] rcnt_q [4];
  logic [RW-1:0] rcnt_d [4];
  logic [3:0]    rep_pulse;

  // Two-flop synchroniser; key_n is inverted so 1 means pressed.
  always_comb begin
    sync1_d = ~key_n;
    sync2_d = sync1_q;
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES of disagreement;
  // a single agreeing cycle restarts the count.
  always_comb begin
    level_d = level_q;
    for (int n = 0; n < 4; n++) begin
      dcnt_d[n] = dcnt_q[n];
      if (sync2_q[n] == level_q[n]) begin
        dcnt_d[n] = '0;
      end else if (dcnt_q[n] == DCNT_TC) begin
        level_d[n] = sync2_q[n];
        dcnt_d[n]  = '0;
      end else begin
        dcnt_d[n] = dcnt_q[n] + DW'(1);
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // Auto-repeat next-state: release wins over everything and never ticks.
  always_comb begin
    rep_pulse = '0;
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      rcnt_d[n]  = rcnt_q[n];
      if (!REPEAT_MASK[n] || release_d[n]) begin
        state_d[n] = RPT_IDLE;
        rcnt_d[n]  = '0;
      end else if (press_d[n]) begin
        state_d[n] = RPT_DELAY;
        rcnt_d[n]  = '0;
      end else begin
        case (state_q[n])
          RPT_IDLE: begin
            rcnt_d[n] = '0;
          end
          RPT_DELAY: begin
            if (rcnt_q[n] == RDLY_TC) begin
              rep_pulse[n] = 1'b1;
              rcnt_d[n]    = '0;
              state_d[n]   = RPT_REPEAT;
            end else begin
              rcnt_d[n] = rcnt_q[n] + RW'(1);
            end
          end
          RPT_REPEAT: begin
            if (rcnt_q[n] == RPER_TC) begin
              rep_pulse[n] = 1'b1;
              rcnt_d[n]    = '0;
            end else begin
              rcnt_d[n] = rcnt_q[n] + RW'(1);
            end
          end
          default: begin
            state_d[n] = RPT_IDLE;
            rcnt_d[n]  = '0;
          end
        endcase
      end
    end
  end

  // Tick is the press itself plus every repeat pulse, registered.
  always_comb begin
    tick_d = press_d | rep_pulse;
  end

  // State registers; reset clears everything so no pulse can escape.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      tick_q    <= '0;
      for (int n = 0; n < 4; n++) begin
        dcnt_q[n]  <= '0;
        state_q[n] <= RPT_IDLE;
        rcnt_q[n]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      tick_q    <= tick_d;
      for (int n = 0; n < 4; n++) begin
        dcnt_q[n]  <= dcnt_d[n];
        state_q[n] <= state_d[n];
        rcnt_q[n]  <= rcnt_d[n];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_tick    = tick_q;

endmodule

// File: tb/tb_timerwithclock_button_conditioner.sv
// Bench for the button conditioner: directed scenarios plus random key
// activity, every cycle compared against a behavioural model.
module tb_timerwithclock_button_conditioner;

  localparam int         D    = 4;
  localparam int         RD   = 8;
  localparam int         RP   = 3;
  localparam logic [3:0] MASK = 4'b0011;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_n;
  logic [3:0] btn_level, btn_press, btn_release, btn_tick;

  timerwithclock_button_conditioner #(
    .DEBOUNCE_CYCLES     (D),
    .REPEAT_DELAY_CYCLES (RD),
    .REPEAT_PERIOD_CYCLES(RP),
    .REPEAT_MASK         (MASK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_tick   (btn_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: synchroniser pipe, run length of disagreement, and time held since press.
  logic [3:0] mask_v;
  logic       m_s1 [4];
  logic       m_s2 [4];
  logic       m_lvl [4];
  int         m_run [4];
  int         m_age [4];
  logic [3:0] e_level, e_press, e_release, e_tick;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_s1[n] = 1'b0; m_s2[n] = 1'b0; m_lvl[n] = 1'b0;
      m_run[n] = 0;   m_age[n] = 0;
    end
    e_level = '0; e_press = '0; e_release = '0; e_tick = '0;
  endtask

  task automatic model_step();
    logic old_l, new_l, rep;
    for (int n = 0; n < 4; n++) begin
      old_l = m_lvl[n];
      new_l = old_l;
      if (m_s2[n] != old_l) begin
        m_run[n]++;
        if (m_run[n] == D) begin
          new_l = m_s2[n];
          m_run[n] = 0;
        end
      end else begin
        m_run[n] = 0;
      end
      rep = 1'b0;
      if (new_l && !old_l) begin
        m_age[n] = 0;
      end else if (new_l && old_l) begin
        m_age[n]++;
        if (mask_v[n] && m_age[n] >= RD && ((m_age[n] - RD) % RP) == 0) rep = 1'b1;
      end
      e_level[n]   = new_l;
      e_press[n]   = new_l & ~old_l;
      e_release[n] = old_l & ~new_l;
      e_tick[n]    = e_press[n] | rep;
      m_lvl[n]     = new_l;
      m_s2[n]      = m_s1[n];
      m_s1[n]      = ~key_n[n];
    end
  endtask

  task automatic check_outputs();
    chk("level",   32'(btn_level),   32'(e_level));
    chk("press",   32'(btn_press),   32'(e_press));
    chk("release", 32'(btn_release), 32'(e_release));
    chk("tick",    32'(btn_tick),    32'(e_tick));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse lasting one edge, checked immediately on assertion.
  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    cycle();
    reset_n = 1'b1;
  endtask

  int lat;
  int cnt_a;
  int cnt_b;

  initial begin
    mask_v  = MASK;
    key_n   = 4'hF;
    reset_n = 1'b0;
    model_reset();

    // Reset with keys idle, then a mid-cycle reset, then 50 quiet cycles.
    repeat (2) cycle();
    reset_n = 1'b1;
    repeat (5) cycle();
    #2;
    reset_pulse();
    repeat (50) cycle();

    // Clean press on channel 0 held long enough to repeat, then release.
    key_n[0] = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (btn_level[0] && lat == 0) lat = i;
    end
    chk("press_latency", 32'(lat), 32'd6);
    key_n[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (btn_release[0] && lat == 0) lat = i;
    end
    chk("release_latency", 32'(lat), 32'd6);

    // Bounce on channel 1 (low 2 / high 1), then a steady hold.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 20; i++) begin
      key_n[1] = (i % 3 == 2);
      cycle();
      if (btn_level[1] | btn_press[1] | btn_tick[1]) cnt_b++;
    end
    key_n[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (btn_press[1]) cnt_a++;
    end
    chk("bounce_quiet", 32'(cnt_b), 32'd0);
    chk("bounce_presses", 32'(cnt_a), 32'd1);
    key_n[1] = 1'b1;
    repeat (10) cycle();

    // Masked channel 3: a single tick, coincident with the press.
    key_n[3] = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (btn_tick[3]) cnt_a++;
      if (btn_tick[3] && !btn_press[3]) cnt_b++;
    end
    chk("mask_ticks", 32'(cnt_a), 32'd1);
    chk("mask_tick_not_press", 32'(cnt_b), 32'd0);
    key_n[3] = 1'b1;
    repeat (10) cycle();

    // Reset while channel 0 is auto-repeating; expect a fresh press after release.
    key_n[0] = 1'b0;
    repeat (20) cycle();
    #2;
    reset_pulse();
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      if (btn_press[0] && lat == 0) lat = i;
    end
    chk("press_after_reset", 32'(lat), 32'd6);
    key_n[0] = 1'b1;
    repeat (10) cycle();

    // Random key activity with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 99) < 4) key_n[n] = ~key_n[n];
      end
      if ($urandom_range(0, 999) == 0) begin
        #2;
        reset_pulse();
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timerwithclock_button_conditioner.md
# timerwithclock_button_conditioner

Conditions the four raw, active-low push-button inputs of the alarm-clock board before they reach the BUTTONS parallel input port and the time-setting logic. Each channel is double-flop synchronised, debounced with a stability counter, and converted to active-high level, press/release pulses, and an auto-repeat tick for hold-to-increment time setting. The `btn_level` output drives the BUTTONS port `in_port[3:0]` directly.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥1.
- `REPEAT_DELAY_CYCLES`, 25000000: hold time from press to first repeat tick (0.5 s); must be ≥1.
- `REPEAT_PERIOD_CYCLES`, 5000000: interval between subsequent repeat ticks (0.1 s); must be ≥1.
- `REPEAT_MASK`, 4'b1111: bit n = 1 enables auto-repeat on channel n.

- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `key_n`  in  4  raw buttons, active-low, asynchronous to `clk`.
- `btn_level`  out  4  debounced level, 1 = pressed; feeds BUTTONS `in_port`.
- `btn_press`  out  4  one-cycle pulse on debounced 0→1.
- `btn_release`  out  4  one-cycle pulse on debounced 1→0.
- `btn_tick`  out  4  one-cycle pulse on the press, then on each auto-repeat.

## Operation
- Per-channel logic is fully independent. Channels never interact.
- Synchroniser: `s1 <= ~key_n[n]`, `s2 <= s1`. Both reset to 0 (released).
- Debounce: counter `dcnt` with width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 == btn_level`, then `dcnt <= 0`.
  - Otherwise, if `dcnt == DEBOUNCE_CYCLES-1`, then `btn_level <= s2` and `dcnt <= 0`.
  - Otherwise, `dcnt <= dcnt+1`.
  - Any single cycle of agreement restarts the count. This rejects bounce.
- Pulses are registered and asserted for exactly one cycle:
  - `btn_press` is set on the same edge where `btn_level` goes 0→1.
  - `btn_release` is set on the same edge where `btn_level` goes 1→0.
- Auto-repeat FSM per channel has states IDLE, DELAY, REPEAT and counter `rcnt` sized for `max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES)`.
  - IDLE → DELAY, `rcnt <= 0`: on the press edge.
  - DELAY: `rcnt` increments each cycle. When `rcnt == REPEAT_DELAY_CYCLES-1`, emit a repeat pulse, `rcnt <= 0`, and go to REPEAT.
  - REPEAT: when `rcnt == REPEAT_PERIOD_CYCLES-1`, emit a repeat pulse and set `rcnt <= 0`. Otherwise increment.
  - Any state → IDLE, `rcnt <= 0`: on the release edge. No repeat pulse is emitted on that edge.
  - If `REPEAT_MASK[n] = 0`, the channel's FSM stays in IDLE.
- `btn_tick = btn_press | repeat_pulse`. It is registered, so it is glitch-free.

## Timing
- Reset: all synchroniser, counter, FSM and output registers clear asynchronously. All outputs read 0. The FSM is in IDLE.
- Reset release is sampled by the normal flop structure. No reset synchroniser is included; it is provided upstream.
- Press latency: `key_n` goes low before edge 1. `s2 = 1` after edge 2. `btn_level`, `btn_press` and `btn_tick` go high after edge `2+DEBOUNCE_CYCLES`. Release latency is identical.
- First repeat tick: press edge E, then a tick after edge `E+REPEAT_DELAY_CYCLES`. Further ticks follow every `REPEAT_PERIOD_CYCLES` edges while held.
- A button held through reset deassertion is seen as a new press after `2+DEBOUNCE_CYCLES` cycles and generates `btn_press`.
- Reset asserted mid-hold or mid-debounce discards all state. No pulse is emitted when reset asserts.
- Counters never wrap: `dcnt` and `rcnt` reset at their terminal compare. Widths must hold the maximum count.
- Pulses on different channels may coincide. No arbitration is applied.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES=4`, `REPEAT_DELAY_CYCLES=8`, `REPEAT_PERIOD_CYCLES=3`, `REPEAT_MASK=4'b0011`.
- **Reset:** assert `reset_n=0` mid-cycle with `key_n=4'hF`. All outputs must be 0 immediately (asynchronously). After release with keys idle, outputs must stay 0 for 50 cycles.
- **Clean press:** drive `key_n[0]` low at edge 0 and hold. `btn_level[0]` must rise after edge 6. `btn_press[0]` and `btn_tick[0]` must be high for exactly the cycle following edge 6.
- **Bounce:** toggle `key_n[1]` low/high with a 3-cycle period for 20 cycles, then hold low. There must be no output activity until 6 cycles after the final low. There must be exactly one `btn_press[1]`.
- **Auto-repeat:** hold `key_n[0]` low for 30 cycles after the press edge E. `btn_tick[0]` must fire at E, E+8, E+11, E+14, and so on. Releasing must give `btn_release[0]` after 6 cycles, with no tick on the release edge.
- **Mask:** hold `key_n[3]` low for 40 cycles. There must be exactly one `btn_tick[3]`, coincident with `btn_press[3]`.
- **Reset mid-hold:** with `key_n[0]` held and the FSM in REPEAT, pulse `reset_n` low for 1 cycle. All outputs must clear. A fresh `btn_press[0]` must appear 6 cycles after reset release.
